gameplay_sm: RTL and testbench
==============================

# gameplay_sm

Control FSM for a 16-card memory ("concentration") game. It seeds the game board in an external 16×6 card RAM, accepts two card selections per turn, and compares them. It writes face-up, matched or face-down status back to the RAM and ends the game after 8 pairs. It sits between the input/debounce logic and the card RAM, and the display logic reads its outputs.

## Interface
- No parameters.
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  level; in QI, starts a new game.
- Select  in  1  one-cycle pulse; selects the card at CardSelectLoc.
- seed  in  8  layout seed; sampled in QINIT and must be stable there.
- CardSelectData  in  6  RAM word at CardSelectLoc; valid while Select=1.
- CardSelectLoc  in  4  board location being selected.
- Ack  in  1  one-cycle pulse; acknowledges the shown pair or the end of the game.
- state  out  8  one-hot current state.
- WriteEnable  out  1  RAM write strobe; high for one cycle per write.
- CARD1, CARD2  out  4  locations of the first and second picks.
- dataOut  out  6  RAM write data.
- dataLoc  out  4  RAM write address.

## Operation
- RAM word layout: [5] matched, [4] face-up, [3] 0, [2:0] pair symbol.
- QI=8'h01: idle. If Start=1, clear cnt and pairs, then go to QINIT.
- QINIT=8'h02: one write per cycle for cnt = 0..15.
  - dataLoc = (cnt + seed[7:4]) ^ seed[3:0], modulo 16. This is a bijection, so the layout is a valid shuffle.
  - dataOut = {3'b000, cnt[3:1]}.
  - After cnt = 15, go to QSEL1.
- QSEL1=8'h04: a Select with CardSelectData[5:4] = 0 is valid. On a valid Select:
  - CARD1 <= CardSelectLoc; sym1 <= CardSelectData[2:0].
  - Write CardSelectData | 6'h10 (face-up) to CardSelectLoc.
  - Go to QSEL2.
  - Invalid Selects are ignored.
- QSEL2=8'h08: same as QSEL1, but a Select is also invalid if CardSelectLoc == CARD1. A valid Select latches CARD2 and sym2, writes face-up, and goes to QCMP.
- QCMP=8'h10: match <= (sym1 == sym2); if match, pairs++. Then go to QSHOW.
- QSHOW=8'h20: both cards stay face-up until Ack, then go to QUPD.
- QUPD=8'h40: two writes.
  - First write: CARD1. Second write: CARD2.
  - Data on a match: {2'b11, 1'b0, sym}. Data on a miss: {2'b00, 1'b0, sym}.
  - Then go to QDONE if pairs == 8, else QSEL1.
- QDONE=8'h80: on Ack, go to QI.
- Select is ignored outside QSEL1/QSEL2. Ack is ignored outside QSHOW/QDONE. Start is ignored outside QI.

## Timing
- Reset values: state = 8'h01. WriteEnable, CARD1, CARD2, dataOut, dataLoc, cnt, pairs, sym1, sym2, match all = 0.
- Reset wins over all other inputs, including mid-game. RAM contents are not cleared on reset; the next QINIT rewrites all 16 words.
- WriteEnable, dataLoc and dataOut are registered.
  - A write decided at edge N is presented during cycle N+1 only.
  - WriteEnable defaults to 0 on every edge with no write decision.
- QINIT takes 16 cycles. The last write (cnt = 15) is visible in the first cycle of QSEL1.
- The face-up write follows a valid Select by one cycle.
- Each QUPD write lasts one cycle, on consecutive cycles.
- Start held high continuously: QI → QINIT happens one cycle after Reset falls.
- Select in the same cycle as the state's entry edge: not evaluated until the next edge. The FSM decides on registered state only.

## Configuration
- GAMEPLAY_SM_SHUFFLE_EN defined: dataLoc during QINIT uses the seed formula above.
- GAMEPLAY_SM_SHUFFLE_EN undefined: seed is ignored and dataLoc = cnt (pair k at locations 2k and 2k+1).

## Structure
- Shared package gameplay_pkg holds:
  - the one-hot state constants (QI..QDONE);
  - the RAM bit positions (MATCHED_BIT = 5, FACEUP_BIT = 4, SYM_W = 3);
  - NUM_PAIRS = 8.
- Optional sub-module gameplay_shuffle: combinational (cnt, seed) → location, holding the macro selection.
- All other logic stays in one FSM module.

## Test plan
- Reset held 10 cycles with Start=1, then released → state 01 → 02. Sixteen write pulses follow; with seed = 0 they write loc i ← i>>1. Then state = 04.
- seed = 8'h35, shuffle enabled → cnt 0 writes loc 6; cnt 15 writes loc 7 (data 7); all 16 locations written exactly once.
- Select loc 0 (data 00), then loc 1 (data 00) → face-up writes 10 to each. Then QCMP → QSHOW. Ack → writes 30 to loc 0 then loc 1 → QSEL1; pairs = 1.
- Mismatch: loc 0 (00) then loc 2 (01) → Ack → writes 00 to loc 0 and 01 to loc 2; pairs unchanged.
- Each of these in QSEL1/QSEL2 → no write, no state change:
  - reselecting CARD1's location;
  - selecting data with bit 5 set;
  - Select pulses in QSHOW.
- All 8 pairs matched → state 80. Ack → 01. Reset asserted mid-QUPD → state 01 next cycle with WriteEnable = 0.

Source files
------------

// File: rtl/gameplay_pkg.sv
// gameplay_pkg -- shared definitions for the memory-game controller.
//   state_t     : one-hot FSM state encoding (QI..QDONE), also driven on the
//                 8-bit state output for the display logic.
//   MATCHED_BIT, FACEUP_BIT, SYM_W : card RAM word layout
//                 [5] matched, [4] face-up, [3] 0, [2:0] pair symbol.
//   NUM_PAIRS   : pairs on the board; the game ends when all are matched.
//   card_word() : packs a card RAM word from its fields.
package gameplay_pkg;

  typedef enum logic [7:0] {
    QI    = 8'h01,
    QINIT = 8'h02,
    QSEL1 = 8'h04,
    QSEL2 = 8'h08,
    QCMP  = 8'h10,
    QSHOW = 8'h20,
    QUPD  = 8'h40,
    QDONE = 8'h80
  } state_t;

  localparam int MATCHED_BIT = 5;
  localparam int FACEUP_BIT  = 4;
  localparam int SYM_W       = 3;
  localparam int NUM_PAIRS   = 8;

  function automatic logic [5:0] card_word(input logic             matched,
                                           input logic             faceup,
                                           input logic [SYM_W-1:0] sym);
    return {matched, faceup, 1'b0, sym};
  endfunction

endpackage

// File: rtl/gameplay_shuffle.sv
// gameplay_shuffle -- combinational board-seeding address generator.
//   cnt  in  4 : card index being seeded (card cnt carries symbol cnt>>1)
//   seed in  8 : layout seed
//   loc  out 4 : board location for card cnt
// Build option: GAMEPLAY_SM_SHUFFLE_EN
//   defined   : loc = (cnt + seed[7:4]) ^ seed[3:0] (mod 16). Adding a
//               constant and XOR-ing a constant are both bijections on 4 bits,
//               so every location is written exactly once.
//   undefined : loc = cnt; seed is ignored and pair k sits at 2k / 2k+1.
module gameplay_shuffle (
  input  logic [3:0] cnt,
  input  logic [7:0] seed,
  output logic [3:0] loc
);

`ifdef GAMEPLAY_SM_SHUFFLE_EN
  assign loc = (cnt + seed[7:4]) ^ seed[3:0];
`else
  logic unused_seed;
  assign unused_seed = ^seed;
  assign loc         = cnt;
`endif

endmodule

// File: rtl/gameplay_sm.sv
// gameplay_sm -- control FSM for a 16-card memory game.
// Seeds the external 16x6 card RAM, takes two picks per turn, compares them,
// writes face-up / matched / face-down status back, and ends after 8 pairs.
//   Clk            in  1 : system clock, rising edge
//   Reset          in  1 : synchronous, active-high reset
//   Start          in  1 : level, starts a game from QI
//   Select         in  1 : pulse, pick the card at CardSelectLoc
//   seed           in  8 : layout seed, sampled during QINIT
//   CardSelectData in  6 : RAM word at CardSelectLoc, valid with Select
//   CardSelectLoc  in  4 : board location being picked
//   Ack            in  1 : pulse, acknowledges the shown pair / game end
//   state          out 8 : one-hot current state
//   WriteEnable    out 1 : registered RAM write strobe, one cycle per write
//   CARD1, CARD2   out 4 : locations of first / second pick
//   dataOut        out 6 : registered RAM write data
//   dataLoc        out 4 : registered RAM write address
// Build option: GAMEPLAY_SM_SHUFFLE_EN (see gameplay_shuffle).
// The card RAM is outside this block and keeps its contents over Reset; the
// next QINIT rewrites every word.
module gameplay_sm
  import gameplay_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Select,
  input  logic [7:0] seed,
  input  logic [5:0] CardSelectData,
  input  logic [3:0] CardSelectLoc,
  input  logic       Ack,
  output logic [7:0] state,
  output logic       WriteEnable,
  output logic [3:0] CARD1,
  output logic [3:0] CARD2,
  output logic [5:0] dataOut,
  output logic [3:0] dataLoc
);

  state_t           state_q, state_n;
  logic [3:0]       cnt_q, cnt_n;
  logic [3:0]       pairs_q, pairs_n;
  logic [SYM_W-1:0] sym1_q, sym1_n;
  logic [SYM_W-1:0] sym2_q, sym2_n;
  logic             match_q, match_n;
  logic             upd2_q, upd2_n;      // QUPD: 0 = writing CARD1, 1 = CARD2
  logic [3:0]       card1_n, card2_n;
  logic             we_n;
  logic [5:0]       data_n;
  logic [3:0]       loc_n;
  logic [3:0]       init_loc;
  logic             card_free;

  gameplay_shuffle u_shuffle (
    .cnt  (cnt_q),
    .seed (seed),
    .loc  (init_loc)
  );

  // A card can be picked only while it is face-down and unmatched.
  assign card_free = !CardSelectData[MATCHED_BIT] && !CardSelectData[FACEUP_BIT];

  assign state = state_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; an unassigned path would infer a latch.
    state_n = state_q;
    cnt_n   = cnt_q;
    pairs_n = pairs_q;
    sym1_n  = sym1_q;
    sym2_n  = sym2_q;
    match_n = match_q;
    upd2_n  = upd2_q;
    card1_n = CARD1;
    card2_n = CARD2;
    we_n    = 1'b0;
    data_n  = dataOut;
    loc_n   = dataLoc;

    case (state_q)
      QI: begin
        if (Start) begin
          cnt_n   = '0;
          pairs_n = '0;
          state_n = QINIT;
        end
      end

      QINIT: begin
        we_n   = 1'b1;
        loc_n  = init_loc;
        data_n = {3'b000, cnt_q[3:1]};
        cnt_n  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_n = QSEL1;
      end

      QSEL1: begin
        if (Select && card_free) begin
          card1_n            = CardSelectLoc;
          sym1_n             = CardSelectData[SYM_W-1:0];
          we_n               = 1'b1;
          loc_n              = CardSelectLoc;
          data_n             = CardSelectData;
          data_n[FACEUP_BIT] = 1'b1;
          state_n            = QSEL2;
        end
      end

      QSEL2: begin
        if (Select && card_free && (CardSelectLoc != CARD1)) begin
          card2_n            = CardSelectLoc;
          sym2_n             = CardSelectData[SYM_W-1:0];
          we_n               = 1'b1;
          loc_n              = CardSelectLoc;
          data_n             = CardSelectData;
          data_n[FACEUP_BIT] = 1'b1;
          state_n            = QCMP;
        end
      end

      QCMP: begin
        match_n = (sym1_q == sym2_q);
        if (sym1_q == sym2_q) pairs_n = pairs_q + 4'd1;
        state_n = QSHOW;
      end

      QSHOW: begin
        if (Ack) begin
          upd2_n  = 1'b0;
          state_n = QUPD;
        end
      end

      QUPD: begin
        we_n = 1'b1;
        if (!upd2_q) begin
          loc_n  = CARD1;
          data_n = card_word(match_q, match_q, sym1_q);
          upd2_n = 1'b1;
        end else begin
          loc_n   = CARD2;
          data_n  = card_word(match_q, match_q, sym2_q);
          upd2_n  = 1'b0;
          state_n = (pairs_q == 4'(NUM_PAIRS)) ? QDONE : QSEL1;
        end
      end

      QDONE: begin
        if (Ack) state_n = QI;
      end

      default: state_n = QI;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (Reset) begin
      state_q     <= QI;
      cnt_q       <= '0;
      pairs_q     <= '0;
      sym1_q      <= '0;
      sym2_q      <= '0;
      match_q     <= 1'b0;
      upd2_q      <= 1'b0;
      CARD1       <= '0;
      CARD2       <= '0;
      WriteEnable <= 1'b0;
      dataOut     <= '0;
      dataLoc     <= '0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      pairs_q     <= pairs_n;
      sym1_q      <= sym1_n;
      sym2_q      <= sym2_n;
      match_q     <= match_n;
      upd2_q      <= upd2_n;
      CARD1       <= card1_n;
      CARD2       <= card2_n;
      WriteEnable <= we_n;
      dataOut     <= data_n;
      dataLoc     <= loc_n;
    end
  end

endmodule

// File: tb/tb_gameplay_sm.sv
// tb_gameplay_sm -- directed self-checking bench for gameplay_sm.
// A behavioural 16x6 card RAM follows the DUT's writes and feeds
// CardSelectData; force_en overrides that data to isolate single rules.
module tb_gameplay_sm;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Select;
  logic [7:0] seed;
  logic [5:0] CardSelectData;
  logic [3:0] CardSelectLoc;
  logic       Ack;
  logic [7:0] state;
  logic       WriteEnable;
  logic [3:0] CARD1;
  logic [3:0] CARD2;
  logic [5:0] dataOut;
  logic [3:0] dataLoc;

  logic [5:0] ram [16];
  logic       force_en;
  logic [5:0] force_data;
  logic [3:0] loc_of [16];
  int         exp_pairs;
  int         n_vec = 0;
  int         n_err = 0;

  gameplay_sm dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Start          (Start),
    .Select         (Select),
    .seed           (seed),
    .CardSelectData (CardSelectData),
    .CardSelectLoc  (CardSelectLoc),
    .Ack            (Ack),
    .state          (state),
    .WriteEnable    (WriteEnable),
    .CARD1          (CARD1),
    .CARD2          (CARD2),
    .dataOut        (dataOut),
    .dataLoc        (dataLoc)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (WriteEnable) ram[dataLoc] <= dataOut;
  end

  assign CardSelectData = force_en ? force_data : ram[CardSelectLoc];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_write(input string tag, input logic [3:0] loc, input logic [5:0] data);
    check({tag, "_we"}, 8'(WriteEnable), 8'h01);
    check({tag, "_loc"}, 8'(dataLoc), 8'(loc));
    check({tag, "_data"}, 8'(dataOut), 8'(data));
  endtask

  task automatic expect_idle(input string tag, input logic [7:0] st);
    check({tag, "_state"}, state, st);
    check({tag, "_we"}, 8'(WriteEnable), 8'h00);
  endtask

  task automatic select(input logic [3:0] loc);
    CardSelectLoc = loc;
    Select        = 1'b1;
    tick();
    Select        = 1'b0;
  endtask

  // Starts from QI (Start asserted by the caller or here) and checks all 16
  // seeding writes. first_loc / last_loc are hand-computed for this seed.
  task automatic run_init(input logic [7:0] s, input logic [3:0] first_loc,
                          input logic [3:0] last_loc);
    int         seen [16];
    int         once;
    logic [3:0] c;
    logic [3:0] el;
    for (int i = 0; i < 16; i++) seen[i] = 0;
    seed  = s;
    Start = 1'b1;
    tick();
    expect_idle("init_entry", 8'h02);
    Start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      c = 4'(i);
`ifdef GAMEPLAY_SM_SHUFFLE_EN
      el = (c + s[7:4]) ^ s[3:0];
`else
      el = c;
`endif
      loc_of[i] = el;
      expect_write("init", el, {3'b000, c[3:1]});
      seen[dataLoc]++;
      if (i == 0)  check("init_first_loc", 8'(dataLoc), 8'(first_loc));
      if (i == 15) check("init_last_loc", 8'(dataLoc), 8'(last_loc));
    end
    check("init_exit_state", state, 8'h04);
    once = 0;
    for (int i = 0; i < 16; i++) if (seen[i] == 1) once++;
    check("init_all_once", 8'(once), 8'd16);
  endtask

  // One full turn: picks a then b (symbols sa/sb), shows, acks and checks
  // both write-backs. probe adds illegal Selects in QSEL2 and QSHOW.
  task automatic turn(input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] sa, input logic [2:0] sb, input bit probe);
    logic m;
    select(a);
    check("sel1_state", state, 8'h08);
    expect_write("sel1", a, {3'b010, sa});
    check("sel1_card1", 8'(CARD1), 8'(a));
    if (probe) begin
      force_en   = 1'b1;
      force_data = 6'h00;
      select(a);
      expect_idle("reselect_card1", 8'h08);
      force_data = 6'h20;
      select(b);
      expect_idle("sel2_matched", 8'h08);
      force_data = 6'h10;
      select(b);
      expect_idle("sel2_faceup", 8'h08);
      force_en   = 1'b0;
    end
    select(b);
    check("sel2_state", state, 8'h10);
    expect_write("sel2", b, {3'b010, sb});
    check("sel2_card2", 8'(CARD2), 8'(b));
    tick();
    expect_idle("show", 8'h20);
    if (probe) begin
      select(b ^ 4'h8);
      expect_idle("show_select", 8'h20);
    end
    m = (sa == sb);
    if (m) exp_pairs++;
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    expect_idle("upd_entry", 8'h40);
    tick();
    expect_write("upd1", a, {m, m, 1'b0, sa});
    tick();
    expect_write("upd2", b, {m, m, 1'b0, sb});
    check("upd_exit_state", state, (exp_pairs == 8) ? 8'h80 : 8'h04);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    Reset         = 1'b1;
    Start         = 1'b1;
    Select        = 1'b0;
    Ack           = 1'b0;
    seed          = 8'h00;
    CardSelectLoc = 4'h0;
    force_en      = 1'b0;
    force_data    = 6'h00;
    exp_pairs     = 0;

    // Reset held with Start high.
    repeat (10) tick();
    expect_idle("reset", 8'h01);
    check("reset_card1", 8'(CARD1), 8'h00);
    check("reset_card2", 8'(CARD2), 8'h00);
    check("reset_data", 8'(dataOut), 8'h00);
    check("reset_loc", 8'(dataLoc), 8'h00);
    Reset = 1'b0;

    // seed 0 gives loc = cnt in either build.
    run_init(8'h00, 4'd0, 4'd15);

    // Mismatch, then a match of pair 0 with illegal-select probes.
    turn(4'd0, 4'd2, 3'd0, 3'd1, 1'b0);
    turn(4'd0, 4'd1, 3'd0, 3'd0, 1'b1);

    // Illegal Selects in QSEL1: a matched card, forced matched, forced face-up.
    select(4'd0);
    expect_idle("sel1_matched_card", 8'h04);
    force_en   = 1'b1;
    force_data = 6'h20;
    select(4'd5);
    expect_idle("sel1_matched_bit", 8'h04);
    force_data = 6'h10;
    select(4'd5);
    expect_idle("sel1_faceup_bit", 8'h04);
    force_en   = 1'b0;

    for (int k = 1; k < 8; k++)
      turn(4'(2 * k), 4'(2 * k + 1), 3'(k), 3'(k), 1'b0);

    select(4'd4);
    expect_idle("done_select", 8'h80);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    expect_idle("done_ack", 8'h01);
    tick();
    expect_idle("idle_hold", 8'h01);

    // Second game with a nonzero seed.
`ifdef GAMEPLAY_SM_SHUFFLE_EN
    run_init(8'h35, 4'd6, 4'd7);
`else
    run_init(8'h35, 4'd0, 4'd15);
`endif
    check("init35_last_data", 8'(dataOut), 8'h07);

    // Reset in the middle of QUPD.
    exp_pairs = 0;
    select(loc_of[0]);
    select(loc_of[1]);
    tick();
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    tick();
    expect_write("midupd", loc_of[0], 6'h30);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    expect_idle("midupd_reset", 8'h01);
    check("midupd_card1", 8'(CARD1), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
